// File: rtl/reg_bank_pkg.sv
// Shared types and helpers for the 16 x 32-bit register bank write side.
// Holds bank geometry, the queued write-back entry and the byte-merge rule.
package reg_bank_pkg;
    localparam int WIDTH  = 32;
    localparam int NREGS  = 16;
    localparam int SELW   = 4;
    localparam int NBYTES = WIDTH / 8;

    typedef struct packed {
        logic [SELW-1:0]   sel;
        logic [WIDTH-1:0]  data;
        logic [NBYTES-1:0] be;
    } wb_entry_t;

    function automatic logic [WIDTH-1:0] byte_merge(
        input logic [WIDTH-1:0]  old_val,
        input logic [WIDTH-1:0]  new_val,
        input logic [NBYTES-1:0] be
    );
        logic [WIDTH-1:0] merged;
        merged = old_val;
        for (int i = 0; i < NBYTES; i++) begin
            if (be[i]) begin
                merged[8*i +: 8] = new_val[8*i +: 8];
            end
        end
        return merged;
    endfunction
endpackage

// File: rtl/wb_fifo2.sv
// Two-entry FIFO of write-back entries; slot 0 is always the head.
// Latency: push visible at head after one edge; no bypass.
// Backpressure: push ignored when full, pop ignored when empty.
module wb_fifo2
    import reg_bank_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            push,
    input  wb_entry_t       push_dat,
    input  logic            pop,
    output wb_entry_t       head_dat,
    output logic            full,
    output logic            empty,
    output logic [1:0]      count,
    output logic            ent0_vld,
    output logic [SELW-1:0] ent0_sel,
    output logic            ent1_vld,
    output logic [SELW-1:0] ent1_sel
);
    wb_entry_t s0_q, s1_q, s0_n, s1_n;
    logic      v0_q, v1_q, v0_n, v1_n;
    logic      do_push, do_pop;

    assign do_push = push && !v1_q;
    assign do_pop  = pop && v0_q;

    // Entries stay compacted toward slot 0, so slot 1 valid means full.
    always_comb begin
        s0_n = s0_q;
        s1_n = s1_q;
        v0_n = v0_q;
        v1_n = v1_q;
        if (do_pop) begin
            s0_n = s1_q;
            v0_n = v1_q;
            v1_n = 1'b0;
        end
        if (do_push) begin
            if (!v0_n) begin
                s0_n = push_dat;
                v0_n = 1'b1;
            end else begin
                s1_n = push_dat;
                v1_n = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s0_q <= '0;
            s1_q <= '0;
            v0_q <= 1'b0;
            v1_q <= 1'b0;
        end else begin
            s0_q <= s0_n;
            s1_q <= s1_n;
            v0_q <= v0_n;
            v1_q <= v1_n;
        end
    end

    assign head_dat = s0_q;
    assign full     = v1_q;
    assign empty    = !v0_q;
    assign count    = {1'b0, v0_q} + {1'b0, v1_q};
    assign ent0_vld = v0_q;
    assign ent0_sel = s0_q.sel;
    assign ent1_vld = v1_q;
    assign ent1_sel = s1_q.sel;
endmodule

// File: rtl/reg_bank_write.sv
// Register bank write side: queues write-backs and byte-merges them into 16 regs.
// Latency: accept at edge N, commit at edge N+1 when commit_en is high.
// Backpressure: wb_ready low while two entries are queued; entries wait for commit_en.
module reg_bank_write
    import reg_bank_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wb_valid,
    output logic              wb_ready,
    input  logic [SELW-1:0]   wb_sel,
    input  logic [WIDTH-1:0]  wb_data,
    input  logic [NBYTES-1:0] wb_be,
    input  logic              commit_en,
    output logic [WIDTH-1:0]  r0,
    output logic [WIDTH-1:0]  r1,
    output logic [WIDTH-1:0]  r2,
    output logic [WIDTH-1:0]  r3,
    output logic [WIDTH-1:0]  r4,
    output logic [WIDTH-1:0]  r5,
    output logic [WIDTH-1:0]  r6,
    output logic [WIDTH-1:0]  r7,
    output logic [WIDTH-1:0]  r8,
    output logic [WIDTH-1:0]  r9,
    output logic [WIDTH-1:0]  r10,
    output logic [WIDTH-1:0]  r11,
    output logic [WIDTH-1:0]  r12,
    output logic [WIDTH-1:0]  r13,
    output logic [WIDTH-1:0]  r14,
    output logic [WIDTH-1:0]  r15,
    output logic [NREGS-1:0]  pending,
    output logic [1:0]        count
);
    logic [WIDTH-1:0] regs [NREGS];
    wb_entry_t        push_dat, head_dat;
    logic             push, pop, full, empty;
    logic             ent0_vld, ent1_vld;
    logic [SELW-1:0]  ent0_sel, ent1_sel;

    assign push_dat = '{sel: wb_sel, data: wb_data, be: wb_be};
    assign wb_ready = !full;
    assign push     = wb_valid && wb_ready;
    assign pop      = commit_en && !empty;

    wb_fifo2 u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .push_dat (push_dat),
        .pop      (pop),
        .head_dat (head_dat),
        .full     (full),
        .empty    (empty),
        .count    (count),
        .ent0_vld (ent0_vld),
        .ent0_sel (ent0_sel),
        .ent1_vld (ent1_vld),
        .ent1_sel (ent1_sel)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < NREGS; k++) begin
                regs[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NREGS; k++) begin
                if (pop && head_dat.sel == SELW'(k)) begin
                    regs[k] <= byte_merge(regs[k], head_dat.data, head_dat.be);
                end
            end
        end
    end

    always_comb begin
        pending = '0;
        for (int k = 0; k < NREGS; k++) begin
            if ((ent0_vld && ent0_sel == SELW'(k)) || (ent1_vld && ent1_sel == SELW'(k))) begin
                pending[k] = 1'b1;
            end
        end
    end

    assign r0  = regs[0];
    assign r1  = regs[1];
    assign r2  = regs[2];
    assign r3  = regs[3];
    assign r4  = regs[4];
    assign r5  = regs[5];
    assign r6  = regs[6];
    assign r7  = regs[7];
    assign r8  = regs[8];
    assign r9  = regs[9];
    assign r10 = regs[10];
    assign r11 = regs[11];
    assign r12 = regs[12];
    assign r13 = regs[13];
    assign r14 = regs[14];
    assign r15 = regs[15];
endmodule

// File: tb/tb_reg_bank_write.sv
// Bench for reg_bank_write: hand-written vector table, multi-cycle sequences,
// and random traffic against a queue/array reference model.
module tb_reg_bank_write;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        wb_valid, wb_ready, commit_en;
    logic [3:0]  wb_sel;
    logic [31:0] wb_data;
    logic [3:0]  wb_be;
    logic [15:0] pending;
    logic [1:0]  count;
    logic [31:0] rr [16];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    reg_bank_write dut (
        .clk(clk), .rst_n(rst_n), .wb_valid(wb_valid), .wb_ready(wb_ready),
        .wb_sel(wb_sel), .wb_data(wb_data), .wb_be(wb_be), .commit_en(commit_en),
        .r0(rr[0]), .r1(rr[1]), .r2(rr[2]), .r3(rr[3]),
        .r4(rr[4]), .r5(rr[5]), .r6(rr[6]), .r7(rr[7]),
        .r8(rr[8]), .r9(rr[9]), .r10(rr[10]), .r11(rr[11]),
        .r12(rr[12]), .r13(rr[13]), .r14(rr[14]), .r15(rr[15]),
        .pending(pending), .count(count)
    );

    typedef struct {
        logic [3:0]  sel;
        logic [31:0] data;
        logic [3:0]  be;
    } ent_t;

    // Reference model: an ordered list of queued writes plus the register contents.
    ent_t        m_q[$];
    logic [31:0] m_regs [16];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic model_edge(input logic rst, input logic v, input ent_t e, input logic ce);
        bit   acc;
        ent_t h;
        if (!rst) begin
            m_q.delete();
            for (int k = 0; k < 16; k++) m_regs[k] = 32'h0;
        end else begin
            acc = v && (m_q.size() < 2);
            if (ce && m_q.size() > 0) begin
                h = m_q.pop_front();
                for (int b = 0; b < 4; b++)
                    if (h.be[b]) m_regs[h.sel][8*b +: 8] = h.data[8*b +: 8];
            end
            if (acc) m_q.push_back(e);
        end
    endtask

    task automatic model_check();
        logic [15:0] exp_pend;
        exp_pend = '0;
        foreach (m_q[i]) exp_pend[m_q[i].sel] = 1'b1;
        for (int k = 0; k < 16; k++) chk($sformatf("model_r%0d", k), rr[k], m_regs[k]);
        chk("model_count", {30'b0, count}, m_q.size());
        chk("model_pending", {16'b0, pending}, {16'b0, exp_pend});
        chk("model_ready", {31'b0, wb_ready}, {31'b0, m_q.size() < 2});
    endtask

    // Drive one cycle, advance one rising edge, then compare against the model.
    task automatic tick(input logic rst, input logic v, input logic [3:0] sel,
                        input logic [31:0] data, input logic [3:0] be, input logic ce);
        ent_t e;
        rst_n = rst; wb_valid = v; wb_sel = sel; wb_data = data; wb_be = be; commit_en = ce;
        e.sel = sel; e.data = data; e.be = be;
        model_edge(rst, v, e, ce);
        @(posedge clk);
        #1;
        model_check();
    endtask

    typedef struct {
        logic        v;
        logic [3:0]  sel;
        logic [31:0] data;
        logic [3:0]  be;
        logic        ce;
        logic [3:0]  chk_sel;
        logic [31:0] exp_r;
        logic [1:0]  exp_cnt;
        logic [15:0] exp_pend;
        logic        exp_rdy;
    } vec_t;

    vec_t tbl [15];

    initial begin
        tbl[0]  = '{1'b1, 4'd5, 32'hDEADBEEF, 4'hF, 1'b1, 4'd5, 32'h0,        2'd1, 16'h0020, 1'b1};
        tbl[1]  = '{1'b0, 4'd0, 32'h0,        4'h0, 1'b1, 4'd5, 32'hDEADBEEF, 2'd0, 16'h0000, 1'b1};
        tbl[2]  = '{1'b1, 4'd1, 32'h11111111, 4'hF, 1'b0, 4'd1, 32'h0,        2'd1, 16'h0002, 1'b1};
        tbl[3]  = '{1'b1, 4'd2, 32'h22222222, 4'hF, 1'b0, 4'd1, 32'h0,        2'd2, 16'h0006, 1'b0};
        tbl[4]  = '{1'b1, 4'd3, 32'h33333333, 4'hF, 1'b0, 4'd2, 32'h0,        2'd2, 16'h0006, 1'b0};
        tbl[5]  = '{1'b0, 4'd0, 32'h0,        4'h0, 1'b1, 4'd1, 32'h11111111, 2'd1, 16'h0004, 1'b1};
        tbl[6]  = '{1'b0, 4'd0, 32'h0,        4'h0, 1'b1, 4'd2, 32'h22222222, 2'd0, 16'h0000, 1'b1};
        tbl[7]  = '{1'b1, 4'd3, 32'hAABBCCDD, 4'hF, 1'b1, 4'd3, 32'h0,        2'd1, 16'h0008, 1'b1};
        tbl[8]  = '{1'b1, 4'd3, 32'h11223344, 4'h5, 1'b1, 4'd3, 32'hAABBCCDD, 2'd1, 16'h0008, 1'b1};
        tbl[9]  = '{1'b1, 4'd3, 32'hFFFFFFFF, 4'h0, 1'b1, 4'd3, 32'hAA22CC44, 2'd1, 16'h0008, 1'b1};
        tbl[10] = '{1'b0, 4'd0, 32'h0,        4'h0, 1'b1, 4'd3, 32'hAA22CC44, 2'd0, 16'h0000, 1'b1};
        tbl[11] = '{1'b1, 4'd7, 32'h00000001, 4'hF, 1'b0, 4'd7, 32'h0,        2'd1, 16'h0080, 1'b1};
        tbl[12] = '{1'b1, 4'd7, 32'h00000200, 4'h2, 1'b0, 4'd7, 32'h0,        2'd2, 16'h0080, 1'b0};
        tbl[13] = '{1'b0, 4'd0, 32'h0,        4'h0, 1'b1, 4'd7, 32'h00000001, 2'd1, 16'h0080, 1'b1};
        tbl[14] = '{1'b0, 4'd0, 32'h0,        4'h0, 1'b1, 4'd7, 32'h00000201, 2'd0, 16'h0000, 1'b1};

        for (int k = 0; k < 16; k++) m_regs[k] = 32'h0;

        // Reset held for two cycles, with a request present that must be ignored.
        tick(1'b0, 1'b1, 4'd4, 32'h12345678, 4'hF, 1'b1);
        tick(1'b0, 1'b1, 4'd4, 32'h12345678, 4'hF, 1'b1);
        chk("reset_count", {30'b0, count}, 32'd0);
        chk("reset_pending", {16'b0, pending}, 32'd0);
        chk("reset_ready", {31'b0, wb_ready}, 32'd1);
        chk("reset_r4", rr[4], 32'd0);

        for (int i = 0; i < 15; i++) begin
            tick(1'b1, tbl[i].v, tbl[i].sel, tbl[i].data, tbl[i].be, tbl[i].ce);
            chk($sformatf("vec%0d_count", i), {30'b0, count}, {30'b0, tbl[i].exp_cnt});
            chk($sformatf("vec%0d_pending", i), {16'b0, pending}, {16'b0, tbl[i].exp_pend});
            chk($sformatf("vec%0d_ready", i), {31'b0, wb_ready}, {31'b0, tbl[i].exp_rdy});
            chk($sformatf("vec%0d_r%0d", i, tbl[i].chk_sel), rr[tbl[i].chk_sel], tbl[i].exp_r);
        end

        // Continuous valid with commit enabled: steady count of one, one commit per cycle.
        tick(1'b1, 1'b1, 4'd8, 32'h80000000, 4'hF, 1'b1);
        for (int i = 0; i < 6; i++) begin
            tick(1'b1, 1'b1, 4'd8 + 4'(i + 1), 32'h80000001 + 32'(i), 4'hF, 1'b1);
            chk($sformatf("stream%0d_count", i), {30'b0, count}, 32'd1);
            chk($sformatf("stream%0d_r%0d", i, 8 + i), rr[8 + i], 32'h80000000 + 32'(i));
        end
        tick(1'b1, 1'b0, 4'd0, 32'h0, 4'h0, 1'b1);
        chk("stream_last_r14", rr[14], 32'h80000006);

        // Reset with two writes queued: neither may ever land.
        tick(1'b1, 1'b1, 4'd9, 32'h99999999, 4'hF, 1'b0);
        tick(1'b1, 1'b1, 4'd10, 32'hAAAAAAAA, 4'hF, 1'b0);
        chk("midrst_pre_count", {30'b0, count}, 32'd2);
        tick(1'b0, 1'b1, 4'd11, 32'hBBBBBBBB, 4'hF, 1'b1);
        tick(1'b1, 1'b0, 4'd0, 32'h0, 4'h0, 1'b1);
        tick(1'b1, 1'b0, 4'd0, 32'h0, 4'h0, 1'b1);
        chk("midrst_count", {30'b0, count}, 32'd0);
        chk("midrst_pending", {16'b0, pending}, 32'd0);
        chk("midrst_ready", {31'b0, wb_ready}, 32'd1);
        for (int k = 0; k < 16; k++) chk($sformatf("midrst_r%0d", k), rr[k], 32'd0);

        // Random traffic with occasional resets, biased toward a few registers.
        for (int i = 0; i < 2000; i++) begin
            logic [3:0] s;
            s = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
            tick($urandom_range(0, 63) != 0, $urandom_range(0, 3) != 0, s,
                 $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 2) != 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
